// File: rtl/sdram_init_refresh_seq_if.sv
// Command pins and refresh handshake between the SDRAM init/refresh sequencer
// and the rest of the controller.
interface sdram_init_refresh_seq_if #(
  parameter int unsigned AW = 12
);
  logic          sdr_cke;
  logic          sdr_cs_n;
  logic          sdr_ras_n;
  logic          sdr_cas_n;
  logic          sdr_we_n;
  logic [AW-1:0] sdr_addr;
  logic [1:0]    sdr_ba;
  logic          init_done;
  logic          ref_req;
  logic          ref_gnt;
  logic          ref_busy;

  modport master (
    output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    output sdr_addr, sdr_ba, init_done, ref_req, ref_busy,
    input  ref_gnt
  );

  modport slave (
    input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
    input  sdr_addr, sdr_ba, init_done, ref_req, ref_busy,
    output ref_gnt
  );
endinterface

// File: rtl/sdram_init_refresh_seq.sv
// SDRAM power-up sequencer (wait, PRECHARGE ALL, N x AUTO REFRESH, LMR) followed
// by periodic refresh requests executed on arbiter grant.
module sdram_init_refresh_seq #(
  parameter int unsigned INIT_CYCLES    = 10000,
  parameter int unsigned T_RP           = 2,
  parameter int unsigned T_RFC          = 7,
  parameter int unsigned T_MRD          = 2,
  parameter int unsigned INIT_REFRESHES = 8,
  parameter int unsigned REF_INTERVAL   = 1560,
  parameter int unsigned AW             = 12,
  parameter logic [AW-1:0] MODE_REG     = 12'h033
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sdram_init_refresh_seq_if.master sdr
);

  localparam int unsigned CNT_MAX01 = (INIT_CYCLES > T_RP)  ? INIT_CYCLES : T_RP;
  localparam int unsigned CNT_MAX23 = (T_RFC > T_MRD)       ? T_RFC       : T_MRD;
  localparam int unsigned CNT_MAX   = (CNT_MAX01 > CNT_MAX23) ? CNT_MAX01 : CNT_MAX23;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);
  localparam int unsigned RW        = $clog2(INIT_REFRESHES + 1);
  localparam int unsigned TW        = $clog2(REF_INTERVAL + 1);

  // Wait states hold for (T-1) NOP cycles; the counter starts at 0 on entry.
  localparam int unsigned TRP_LAST  = (T_RP  > 1) ? T_RP  - 2 : 0;
  localparam int unsigned TRFC_LAST = (T_RFC > 1) ? T_RFC - 2 : 0;
  localparam int unsigned TMRD_LAST = (T_MRD > 1) ? T_MRD - 2 : 0;

  localparam logic [AW-1:0] ADDR_A10 = AW'(11'h400);

  typedef enum logic [3:0] {
    CMD_LMR      = 4'b0000,
    CMD_AREF     = 4'b0001,
    CMD_PRE      = 4'b0010,
    CMD_NOP      = 4'b0111,
    CMD_DESELECT = 4'b1111
  } cmd_e;

  typedef enum logic [3:0] {
    ST_RST_WAIT,
    ST_INIT_PRE,
    ST_INIT_TRP,
    ST_INIT_AR,
    ST_INIT_TRFC,
    ST_INIT_LMR,
    ST_INIT_TMRD,
    ST_IDLE,
    ST_REF_PRE,
    ST_REF_TRP,
    ST_REF_AR,
    ST_REF_TRFC
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_icnt;
  logic [RW-1:0] w_icnt_inc;
  logic [TW-1:0] r_tmr;
  logic [2:0]    r_pend;
  logic          r_init_done;
  logic          r_cke;
  cmd_e          r_cmd;
  cmd_e          w_cmd_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic          w_counting;
  logic          w_expire;
  logic          w_dec;
  logic          w_ref_req;

  assign w_icnt_inc = r_icnt + RW'(1);
  assign w_ref_req  = (r_state == ST_IDLE) && (r_pend != 3'd0);
  assign w_expire   = r_init_done && (r_tmr == TW'(REF_INTERVAL - 1));
  assign w_dec      = (r_state == ST_REF_AR);
  assign w_counting = (r_state == ST_RST_WAIT)  || (r_state == ST_INIT_TRP) ||
                      (r_state == ST_INIT_TRFC) || (r_state == ST_INIT_TMRD) ||
                      (r_state == ST_REF_TRP)   || (r_state == ST_REF_TRFC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST_WAIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_counting) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Command pins are registered from the next state so each command appears
  // for exactly the cycle the FSM spends in the matching state.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = CMD_NOP;
    w_addr_nxt  = '0;

    case (r_state)
      ST_RST_WAIT:
        if (r_cnt == CW'(INIT_CYCLES)) w_state_nxt = ST_INIT_PRE;
      ST_INIT_PRE:
        w_state_nxt = (T_RP > 1) ? ST_INIT_TRP : ST_INIT_AR;
      ST_INIT_TRP:
        if (r_cnt == CW'(TRP_LAST)) w_state_nxt = ST_INIT_AR;
      ST_INIT_AR:
        if (T_RFC > 1)                             w_state_nxt = ST_INIT_TRFC;
        else if (w_icnt_inc < RW'(INIT_REFRESHES)) w_state_nxt = ST_INIT_AR;
        else                                       w_state_nxt = ST_INIT_LMR;
      ST_INIT_TRFC:
        if (r_cnt == CW'(TRFC_LAST))
          w_state_nxt = (r_icnt < RW'(INIT_REFRESHES)) ? ST_INIT_AR : ST_INIT_LMR;
      ST_INIT_LMR:
        w_state_nxt = (T_MRD > 1) ? ST_INIT_TMRD : ST_IDLE;
      ST_INIT_TMRD:
        if (r_cnt == CW'(TMRD_LAST)) w_state_nxt = ST_IDLE;
      ST_IDLE:
        if (w_ref_req && sdr.ref_gnt) w_state_nxt = ST_REF_PRE;
      ST_REF_PRE:
        w_state_nxt = (T_RP > 1) ? ST_REF_TRP : ST_REF_AR;
      ST_REF_TRP:
        if (r_cnt == CW'(TRP_LAST)) w_state_nxt = ST_REF_AR;
      ST_REF_AR:
        w_state_nxt = (T_RFC > 1) ? ST_REF_TRFC : ST_IDLE;
      ST_REF_TRFC:
        if (r_cnt == CW'(TRFC_LAST)) w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_RST_WAIT;
    endcase

    case (w_state_nxt)
      ST_INIT_PRE, ST_REF_PRE: begin
        w_cmd_nxt  = CMD_PRE;
        w_addr_nxt = ADDR_A10;
      end
      ST_INIT_AR, ST_REF_AR: w_cmd_nxt = CMD_AREF;
      ST_INIT_LMR: begin
        w_cmd_nxt  = CMD_LMR;
        w_addr_nxt = MODE_REG;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cke  <= 1'b0;
      r_cmd  <= CMD_DESELECT;
      r_addr <= '0;
    end else begin
      r_cke  <= 1'b1;
      r_cmd  <= w_cmd_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icnt      <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (r_state == ST_INIT_AR) r_icnt <= w_icnt_inc;
      if (w_state_nxt == ST_IDLE) r_init_done <= 1'b1;
    end
  end

  // Timer idles at 0 until init completes, so the first expiry lands
  // REF_INTERVAL cycles after init_done rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr  <= '0;
      r_pend <= '0;
    end else begin
      if (r_init_done) begin
        r_tmr <= w_expire ? '0 : r_tmr + TW'(1);
      end
      case ({w_expire, w_dec})
        2'b10:   if (r_pend != 3'd7) r_pend <= r_pend + 3'd1;
        2'b01:   r_pend <= r_pend - 3'd1;
        default: ;
      endcase
    end
  end

  assign sdr.sdr_cke   = r_cke;
  assign sdr.sdr_cs_n  = r_cmd[3];
  assign sdr.sdr_ras_n = r_cmd[2];
  assign sdr.sdr_cas_n = r_cmd[1];
  assign sdr.sdr_we_n  = r_cmd[0];
  assign sdr.sdr_addr  = r_addr;
  assign sdr.sdr_ba    = '0;
  assign sdr.init_done = r_init_done;
  assign sdr.ref_req   = w_ref_req;
  assign sdr.ref_busy  = (r_state == ST_REF_PRE) || (r_state == ST_REF_TRP) ||
                         (r_state == ST_REF_AR)  || (r_state == ST_REF_TRFC);

endmodule

// File: tb/tb_sdram_init_refresh_seq.sv
// Directed bench for sdram_init_refresh_seq: init sequence, periodic refresh,
// pending saturation, grant handling and mid-sequence reset.
module tb_sdram_init_refresh_seq;

  localparam logic [3:0] C_DES  = 4'b1111;
  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd;
  int unsigned n_run;
  int unsigned n_fail;
  int unsigned e;

  sdram_init_refresh_seq_if #(.AW(12)) sdr_if ();

  sdram_init_refresh_seq #(
    .INIT_CYCLES    (20),
    .T_RP           (2),
    .T_RFC          (3),
    .T_MRD          (2),
    .INIT_REFRESHES (2),
    .REF_INTERVAL   (50),
    .AW             (12),
    .MODE_REG       (12'h033)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sdr   (sdr_if)
  );

  assign cmd = {sdr_if.sdr_cs_n, sdr_if.sdr_ras_n, sdr_if.sdr_cas_n, sdr_if.sdr_we_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] x_cmd, input logic [11:0] x_addr,
                         input logic x_cke, input logic x_done, input logic x_req,
                         input logic x_busy);
    string t;
    t = $sformatf("%s@%0d", tag, e);
    cmp({t, ".cmd"},  12'(cmd),                 12'(x_cmd));
    cmp({t, ".addr"}, sdr_if.sdr_addr,          x_addr);
    cmp({t, ".ba"},   12'(sdr_if.sdr_ba),       12'h000);
    cmp({t, ".cke"},  12'(sdr_if.sdr_cke),      12'(x_cke));
    cmp({t, ".done"}, 12'(sdr_if.init_done),    12'(x_done));
    cmp({t, ".req"},  12'(sdr_if.ref_req),      12'(x_req));
    cmp({t, ".busy"}, 12'(sdr_if.ref_busy),     12'(x_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  // Edges counted from reset release; PRE@21, AREF@23/26, LMR@29, done from 31.
  task automatic check_init(input int unsigned last);
    logic [3:0]  xc;
    logic [11:0] xa;
    for (int unsigned k = 1; k <= last; k++) begin
      tick();
      xc = C_NOP;
      xa = 12'h000;
      if (k == 21) begin xc = C_PRE; xa = 12'h400; end
      if (k == 23 || k == 26) xc = C_AREF;
      if (k == 29) begin xc = C_LMR; xa = 12'h033; end
      chk_out("init", xc, xa, 1'b1, (k >= 31), 1'b0, 1'b0);
    end
  endtask

  task automatic idle_span(input int unsigned n, input logic x_req);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      chk_out("idle", C_NOP, 12'h000, 1'b1, 1'b1, x_req, 1'b0);
    end
  endtask

  // Caller is at an IDLE negedge with ref_req=1 and ref_gnt=1.
  task automatic ref_seq(input logic drop_gnt, input logic req_after);
    tick();
    if (drop_gnt) sdr_if.ref_gnt = 1'b0;
    chk_out("ref_pre", C_PRE, 12'h400, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("ref_trp", C_NOP, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("ref_ar", C_AREF, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int unsigned k = 0; k < 2; k++) begin
      tick();
      chk_out("ref_trfc", C_NOP, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    tick();
    chk_out("ref_end", C_NOP, 12'h000, 1'b1, 1'b1, req_after, 1'b0);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk_out(tag, C_DES, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_out(tag, C_DES, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    e = 0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    e      = 0;
    rst_n  = 1'b0;
    sdr_if.ref_gnt = 1'b0;

    // Reset held for 5 cycles: DESELECT, cke low.
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_out("reset", C_DES, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    check_init(32);

    // Grant while no request pending is ignored.
    sdr_if.ref_gnt = 1'b1;
    idle_span(8, 1'b0);
    sdr_if.ref_gnt = 1'b0;
    idle_span(30, 1'b0);

    // Grant tied high: first expiry 50 edges after init_done (edge 81).
    sdr_if.ref_gnt = 1'b1;
    idle_span(10, 1'b0);
    idle_span(1, 1'b1);
    ref_seq(1'b0, 1'b0);
    idle_span(43, 1'b0);

    // Grant withheld across 8 expiries: pending saturates at 7.
    sdr_if.ref_gnt = 1'b0;
    idle_span(1, 1'b1);
    idle_span(401, 1'b1);

    // Drain: seven handshakes, then quiet until the next expiry at edge 581.
    for (int unsigned i = 0; i < 7; i++) begin
      sdr_if.ref_gnt = 1'b1;
      ref_seq(1'b1, (i < 6));
    end
    idle_span(6, 1'b0);
    idle_span(1, 1'b1);

    // Reset during REF_TRP.
    sdr_if.ref_gnt = 1'b1;
    tick();
    sdr_if.ref_gnt = 1'b0;
    chk_out("r5_pre", C_PRE, 12'h400, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("r5_trp", C_NOP, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1);
    reset_pulse("rst_reftrp");
    check_init(24);

    // Reset during INIT_TRFC, then a full init again.
    reset_pulse("rst_inittrfc");
    check_init(32);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", e);
    $fatal(1, "watchdog");
  end

endmodule
